// File: rtl/ofdm_subcarrier_mapper_pkg.sv
// Shared types, default 64-point masks and helpers for the OFDM subcarrier mapper.
package ofdm_pkg;

  // Widest mask supported (NFFT upper limit).
  localparam int MASK_MAX = 1024;

  // Default 64-point slot layout.
  localparam logic [63:0] DEF_NULL_MASK      = 64'h0000_003F_F800_0001;
  localparam logic [63:0] DEF_PILOT_MASK     = 64'h0200_0800_0020_0080;
  localparam logic [63:0] DEF_PILOT_NEG_MASK = 64'h0000_0000_0020_0000;
  localparam logic [15:0] DEF_PILOT_AMP      = 16'h7FFF;

  // Pilot polarity scrambler x^7 + x^4 + 1.
  localparam int          LFSR_W        = 7;
  localparam int          LFSR_TAP_A    = 6;
  localparam int          LFSR_TAP_B    = 3;
  localparam logic [6:0]  DEF_LFSR_SEED = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PAD  = 2'd2
  } state_e;

  // Number of set bits in a mask.
  function automatic int popcount_mask(input logic [MASK_MAX-1:0] m);
    int c;
    c = 0;
    for (int i = 0; i < MASK_MAX; i++) begin
      if (m[i]) begin
        c = c + 1;
      end
    end
    return c;
  endfunction

  // Highest slot index below nfft that carries data (occ = null|pilot).
  function automatic int last_data_slot(input logic [MASK_MAX-1:0] occ, input int nfft);
    int r;
    r = 0;
    for (int i = 0; i < MASK_MAX; i++) begin
      if ((i < nfft) && !occ[i]) begin
        r = i;
      end
    end
    return r;
  endfunction

  // Polarity bit of the current LFSR state.
  function automatic logic lfsr_pol(input logic [LFSR_W-1:0] s);
    return s[LFSR_TAP_A] ^ s[LFSR_TAP_B];
  endfunction

endpackage

// File: rtl/ofdm_subcarrier_mapper_lfsr.sv
// Per-symbol pilot polarity generator: 7-bit LFSR, reload at frame start,
// one step per symbol, polarity taken from the current state.
module pilot_pol_lfsr
  import ofdm_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_LFSR_SEED
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_step,
  output logic o_pol
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_pol;

  assign w_pol = lfsr_pol(r_lfsr);
  assign o_pol = w_pol;

  // LFSR state: reload wins over step; shift left feeding the polarity bit back in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= SEED;
    end else if (i_step) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_pol};
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

endmodule

// File: rtl/ofdm_subcarrier_mapper.sv
// OFDM subcarrier mapper: places incoming data subcarriers into an NFFT-slot
// symbol, inserting nulls and scrambled-polarity pilots, and pads truncated
// final symbols so downstream always receives whole symbols.
module ofdm_subcarrier_mapper
  import ofdm_pkg::*;
#(
  parameter int                   DATA_W         = 16,
  parameter int                   NFFT           = 64,
  parameter logic [MASK_MAX-1:0]  NULL_MASK      = MASK_MAX'(DEF_NULL_MASK),
  parameter logic [MASK_MAX-1:0]  PILOT_MASK     = MASK_MAX'(DEF_PILOT_MASK),
  parameter logic [MASK_MAX-1:0]  PILOT_NEG_MASK = MASK_MAX'(DEF_PILOT_NEG_MASK),
  parameter logic [DATA_W-1:0]    PILOT_AMP      = DATA_W'(DEF_PILOT_AMP),
  parameter logic [LFSR_W-1:0]    LFSR_SEED      = DEF_LFSR_SEED
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [2*DATA_W-1:0] s_axis_tdata,
  input  logic                s_axis_tuser,
  input  logic                s_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [2*DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tuser,
  output logic                m_axis_tlast,
  output logic                err_align,
  output logic                err_short,
  output logic                frame_busy
);

  localparam int                KW          = $clog2(NFFT);
  localparam logic [MASK_MAX-1:0] OCC_MASK  = NULL_MASK | PILOT_MASK;
  localparam int                N_DATA      = NFFT - popcount_mask(OCC_MASK);
  localparam int                LAST_DATA_K = last_data_slot(OCC_MASK, NFFT);
  localparam logic [NFFT-1:0]   L_NULL      = NULL_MASK[NFFT-1:0];
  localparam logic [NFFT-1:0]   L_PILOT     = PILOT_MASK[NFFT-1:0];
  localparam logic [NFFT-1:0]   L_NEG       = PILOT_NEG_MASK[NFFT-1:0];
  localparam logic [KW-1:0]     K_END       = KW'(NFFT - 1);
  localparam logic [KW-1:0]     K_LAST_DATA = KW'(LAST_DATA_K);
  localparam logic [DATA_W-1:0] AMP_NEG     = ~PILOT_AMP + DATA_W'(1);
  localparam logic              SEED_POL    = lfsr_pol(LFSR_SEED);

  // Reject configurations that cannot produce a valid symbol layout.
  if ((NFFT < 8) || (NFFT > 1024) || ((NFFT & (NFFT - 1)) != 0)) begin : g_err_nfft
    $error("NFFT must be a power of two in 8..1024");
  end
  if ((NULL_MASK & PILOT_MASK) != '0) begin : g_err_overlap
    $error("NULL_MASK and PILOT_MASK overlap");
  end
  if (N_DATA <= 0) begin : g_err_ndata
    $error("masks leave no data subcarriers");
  end
  if (((NULL_MASK | PILOT_MASK | PILOT_NEG_MASK) >> NFFT) != '0) begin : g_err_width
    $error("mask bits set beyond NFFT");
  end

  state_e              r_state;
  state_e              w_state_nxt;
  logic [KW-1:0]       r_k;
  logic                r_last_seen;
  logic                r_m_tvalid;
  logic [2*DATA_W-1:0] r_m_tdata;
  logic                r_m_tuser;
  logic                r_m_tlast;
  logic                r_err_align;
  logic                r_err_short;

  logic                w_is_null;
  logic                w_is_pilot;
  logic                w_is_data;
  logic                w_slot_end;
  logic                w_last_data;
  logic                w_out_free;
  logic                w_active;
  logic                w_pad;
  logic                w_stall;
  logic                w_load;
  logic                w_s_ready;
  logic                w_accept;
  logic                w_frame_done;
  logic                w_short;
  logic                w_misalign;
  logic                w_lfsr_pol;
  logic                w_pol;
  logic                w_pilot_neg;
  logic                w_lfsr_load;
  logic                w_lfsr_step;
  logic [2*DATA_W-1:0] w_slot_data;

  pilot_pol_lfsr #(
    .SEED (LFSR_SEED)
  ) u_pol_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_lfsr_load),
    .i_step (w_lfsr_step),
    .o_pol  (w_lfsr_pol)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: frame end at the symbol-end load, truncation diverts to padding.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!s_axis_tvalid) begin
          w_state_nxt = ST_IDLE;
        end else if (w_short) begin
          w_state_nxt = ST_PAD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_load && w_slot_end && w_frame_done) begin
          w_state_nxt = ST_IDLE;
        end else if (w_short) begin
          w_state_nxt = ST_PAD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PAD: begin
        if (w_load && w_slot_end) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PAD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Slot decode, handshake, error detection and slot content selection.
  always_comb begin
    w_is_null    = L_NULL[r_k];
    w_is_pilot   = L_PILOT[r_k];
    w_is_data    = ~(w_is_null | w_is_pilot);
    w_slot_end   = (r_k == K_END);
    w_last_data  = (r_k == K_LAST_DATA);
    w_out_free   = ~r_m_tvalid | m_axis_tready;
    w_pad        = (r_state == ST_PAD);
    case (r_state)
      ST_IDLE: w_active = s_axis_tvalid;
      ST_RUN:  w_active = 1'b1;
      ST_PAD:  w_active = 1'b1;
      default: w_active = 1'b0;
    endcase
    w_stall      = w_is_data & ~w_pad & ~s_axis_tvalid;
    w_load       = w_active & w_out_free & ~w_stall;
    w_s_ready    = w_active & w_out_free & w_is_data & ~w_pad;
    w_accept     = s_axis_tvalid & w_s_ready;
    w_frame_done = w_pad | r_last_seen | (w_accept & s_axis_tlast);
    w_short      = w_accept & s_axis_tlast & ~w_last_data;
    w_misalign   = w_accept & (s_axis_tuser ^ w_last_data);
    // The LFSR is reloaded on the same edge a frame starts, so use the seed polarity then.
    w_pol        = (r_state == ST_IDLE) ? SEED_POL : w_lfsr_pol;
    w_pilot_neg  = L_NEG[r_k] ^ w_pol;
    w_lfsr_load  = (r_state == ST_IDLE) & s_axis_tvalid;
    w_lfsr_step  = w_load & w_slot_end;
    if (w_is_null) begin
      w_slot_data = '0;
    end else if (w_is_pilot) begin
      w_slot_data = {{DATA_W{1'b0}}, (w_pilot_neg ? AMP_NEG : PILOT_AMP)};
    end else if (w_pad) begin
      w_slot_data = '0;
    end else begin
      w_slot_data = s_axis_tdata;
    end
  end

  // Output register, slot counter and frame-end tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k         <= '0;
      r_last_seen <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_m_tdata   <= '0;
      r_m_tuser   <= 1'b0;
      r_m_tlast   <= 1'b0;
    end else begin
      if (w_load) begin
        r_k        <= r_k + KW'(1);
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_slot_data;
        r_m_tuser  <= w_slot_end;
        r_m_tlast  <= w_slot_end & w_frame_done;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end else begin
        r_m_tvalid <= r_m_tvalid;
      end
      if (w_load && w_slot_end && w_frame_done) begin
        r_last_seen <= 1'b0;
      end else if (w_accept && s_axis_tlast) begin
        r_last_seen <= 1'b1;
      end else begin
        r_last_seen <= r_last_seen;
      end
    end
  end

  // One-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_align <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      r_err_align <= w_misalign;
      r_err_short <= w_short;
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tlast  = r_m_tlast;
  assign err_align     = r_err_align;
  assign err_short     = r_err_short;
  assign frame_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
// Scoreboard bench for ofdm_subcarrier_mapper with default 64-point parameters.
module tb_ofdm_subcarrier_mapper;

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        err_align;
  logic        err_short;
  logic        frame_busy;

  beat_t in_q[$];
  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  logic [63:0] nulls   = 64'h0000_003F_F800_0001;
  logic [63:0] pilots  = 64'h0200_0800_0020_0080;
  logic [63:0] negs    = 64'h0000_0000_0020_0000;
  // Pilot polarity for symbols 0..9 of a frame: 0,0,0,0,1,1,1,0,1,1.
  logic [9:0]  pol_tab = 10'b11_0111_0000;

  always #5 clk = ~clk;

  ofdm_subcarrier_mapper dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .err_align     (err_align),
    .err_short     (err_short),
    .frame_busy    (frame_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Queue input beats and the expected output symbols for one frame.
  // short_sym < 0: normal frame of nsym symbols; otherwise tlast on data beat short_d of short_sym.
  task automatic add_frame(input int f, input int nsym, input int short_sym, input int short_d,
                           input int bad_s, input int bad_d);
    int    last_sym;
    int    d;
    int    end_d;
    bit    pad;
    beat_t e;
    beat_t b;
    last_sym = (short_sym >= 0) ? short_sym : nsym - 1;
    for (int s = 0; s <= last_sym; s++) begin
      d     = 0;
      pad   = 1'b0;
      end_d = (s == short_sym) ? short_d : 47;
      for (int k = 0; k < 64; k++) begin
        e.user = (k == 63);
        e.last = (k == 63) && (s == last_sym);
        if (nulls[k]) begin
          e.data = 32'h0;
        end else if (pilots[k]) begin
          e.data = (negs[k] ^ pol_tab[s]) ? 32'h0000_8001 : 32'h0000_7FFF;
        end else if (pad) begin
          e.data = 32'h0;
        end else begin
          b.data = {f[7:0], s[7:0], d[15:0]};
          b.user = (d == 47) || ((s == bad_s) && (d == bad_d));
          b.last = (s == last_sym) && (d == end_d);
          in_q.push_back(b);
          e.data = b.data;
          if (d == end_d) pad = 1'b1;
          d++;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  // Drive queued input and compare every accepted output beat against the scoreboard.
  task automatic run_traffic(input string tag, input int p_valid, input int p_ready,
                             input int stop_after, input int exp_short, input int exp_align);
    int          cyc;
    int          tail;
    int          n_out;
    int          n_sh;
    int          n_al;
    bit          acc;
    bit          pend;
    bit          hold;
    logic [34:0] prev;
    beat_t       e;
    cyc = 0; tail = 0; n_out = 0; n_sh = 0; n_al = 0;
    pend = 1'b0; hold = 1'b0; prev = '0;
    while (cyc < 20000) begin
      if ((stop_after > 0) && (n_out >= stop_after)) break;
      if ((in_q.size() == 0) && (exp_q.size() == 0)) begin
        if (tail >= 4) break;
        tail++;
      end
      @(negedge clk);
      cyc++;
      m_axis_tready = ($urandom_range(99) < p_ready);
      if (in_q.size() > 0) begin
        s_axis_tvalid = pend || ($urandom_range(99) < p_valid);
        {s_axis_tdata, s_axis_tuser, s_axis_tlast} = in_q[0];
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'h0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      #1;
      if (hold) check_eq({tag, " hold"}, {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}, prev);
      hold = m_axis_tvalid && !m_axis_tready;
      prev = {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast};
      if (err_short) n_sh++;
      if (err_align) n_al++;
      acc  = s_axis_tvalid && s_axis_tready;
      pend = s_axis_tvalid && !acc;
      if (m_axis_tvalid && m_axis_tready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_eq({tag, " extra beat"}, 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq(tag, {m_axis_tdata, m_axis_tuser, m_axis_tlast}, {e.data, e.user, e.last});
        end
      end
      @(posedge clk);
      if (acc) void'(in_q.pop_front());
    end
    if (cyc >= 20000) check_eq({tag, " timeout"}, 64'd0, 64'd1);
    if (stop_after == 0) begin
      check_eq({tag, " err_short count"}, 64'(n_sh), 64'(exp_short));
      check_eq({tag, " err_align count"}, 64'(n_al), 64'(exp_align));
      check_eq({tag, " idle busy"}, {63'd0, frame_busy}, 64'd0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'h0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    check_eq("reset state", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                             err_align, err_short, frame_busy, s_axis_tready}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // One 48-beat symbol, data = index, no backpressure.
    add_frame(0, 1, -1, 0, -1, 0);
    run_traffic("single", 100, 100, 0, 0, 0);

    // Ten symbols: pilot polarity sequence across the frame.
    add_frame(1, 10, -1, 0, -1, 0);
    run_traffic("ten_sym", 100, 100, 0, 0, 0);

    // Truncated frame, then a fresh frame starting from the seed.
    add_frame(2, 3, 2, 20, -1, 0);
    add_frame(5, 1, -1, 0, -1, 0);
    run_traffic("short", 100, 100, 0, 1, 0);

    // Random stalls on both sides.
    add_frame(3, 3, -1, 0, -1, 0);
    run_traffic("stall", 60, 50, 0, 0, 0);

    // Spurious tuser on data beat 30.
    add_frame(4, 2, -1, 0, 0, 30);
    run_traffic("align", 100, 100, 0, 0, 1);

    // Reset at slot 40 of symbol 1, then a fresh frame.
    add_frame(6, 3, -1, 0, -1, 0);
    run_traffic("pre_rst", 100, 100, 104, 0, 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid reset", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                           err_align, err_short, frame_busy, s_axis_tready}, 64'd0);
    in_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    add_frame(7, 1, -1, 0, -1, 0);
    run_traffic("post_rst", 100, 100, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ofdm_subcarrier_mapper.md
# ofdm_subcarrier_mapper

Parametrised per-symbol subcarrier mapper for the OFDM transmit chain, between the QAM modulator output stream and the IFFT input. It accepts data subcarriers on AXI-Stream and inserts nulls and pilots according to elaboration-time masks, emitting NFFT samples per symbol in IFFT natural index order. Pilot polarity follows the 127-periodic scrambler sequence x^7+x^4+1 and is advanced once per symbol. The block detects malformed frames and zero-pads truncated final symbols so the IFFT never sees a partial symbol.

## Interface
- DATA_W, 16, bits per I and Q component
- NFFT, 64, subcarriers per symbol (power of two, 8..1024)
- NULL_MASK, 64'h0000_003F_F800_0001, bit k=1 → slot k null (0, 27..37)
- PILOT_MASK, 64'h0200_0800_0020_0080, bit k=1 → slot k pilot (7, 21, 43, 57)
- PILOT_NEG_MASK, 64'h0000_0000_0020_0000, base sign negative at slot k (21)
- PILOT_AMP, 16'h7FFF, pilot real magnitude; imag always 0
- LFSR_SEED, 7'h7F, polarity LFSR load value at frame start
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- s_axis_tvalid  in  1  data subcarrier valid
- s_axis_tready  out  1  data subcarrier accepted
- s_axis_tdata  in  2*DATA_W  {imag, real}
- s_axis_tuser  in  1  last data subcarrier of symbol
- s_axis_tlast  in  1  last data subcarrier of frame
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  2*DATA_W  {imag, real}
- m_axis_tuser  out  1  slot k = NFFT-1 (symbol end)
- m_axis_tlast  out  1  symbol end of the frame's last symbol
- err_align  out  1  one-cycle pulse, tuser misaligned
- err_short  out  1  one-cycle pulse, tlast before last data slot
- frame_busy  out  1  state ≠ IDLE

## Operation
- N_DATA = NFFT − popcount(NULL_MASK | PILOT_MASK). Elaboration error if masks overlap, N_DATA = 0, or masks exceed NFFT bits.
- Slot counter k (log2 NFFT bits) wraps NFFT-1 → 0; advances on every output register load.
- Slot type: null → tdata 0; pilot → real = ±PILOT_AMP (negative is two's complement, 0x8001 for default), imag 0; data → input beat.
- Pilot sign negative iff PILOT_NEG_MASK[k] XOR pol; pol = lfsr[6] XOR lfsr[3] for the current symbol.
- LFSR shifts left with pol fed in, once per symbol when the k = NFFT-1 beat loads. It reloads LFSR_SEED when a frame begins. With the default seed, the first symbols' pol sequence is 0,0,0,0,1,1,1,0.
- States:
  - IDLE: k = 0; nothing emitted. Moves to RUN when s_axis_tvalid is high (the first null is emitted that cycle if the output can load).
  - RUN: emits the slot sequence. Data slots stall until the input beat arrives; nulls and pilots never wait on input.
    - Accepted s_axis_tlast on a data slot other than the symbol's last data slot: pulse err_short, go to PAD.
    - At the k = NFFT-1 load of the frame's final symbol: go to IDLE.
  - PAD: emits the rest of the symbol with data slots zeroed and s_axis_tready = 0. At the k = NFFT-1 load: go to IDLE.
- m_axis_tlast = 1 on the k = NFFT-1 beat of the symbol in which tlast was accepted.
- err_align pulses when:
  - an input beat's tuser ≠ (the beat is the symbol's last data slot), or
  - tlast is accepted without tuser on the last data slot.
  - Data are still mapped by count; tuser is advisory only.

## Timing
- Output register loads when (~m_axis_tvalid | m_axis_tready) and the current slot is not a stalled data slot.
- s_axis_tready = load_ok & (state ≠ PAD) & (data slot). It is combinational from m_axis_tready; no skid buffer.
- Latency: a beat accepted at edge t is presented on m_axis_* from t until accepted.
- Output data and control bits are held stable while m_axis_tvalid & ~m_axis_tready.
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, m_axis_tuser 0, m_axis_tlast 0, err_* 0, frame_busy 0, s_axis_tready 0, k 0, LFSR = LFSR_SEED, state IDLE.
- Reset asserted mid-frame: all outputs clear immediately, the partial symbol is discarded, and no flush occurs.
- tlast arriving with k = NFFT-1 pending: the frame end is honoured on that same beat with no extra symbol.

## Structure
- Package ofdm_pkg:
  - state enum (IDLE, RUN, PAD)
  - default 64-point masks and PILOT_AMP
  - LFSR taps and seed constants
  - popcount function for N_DATA
- Sub-module pilot_pol_lfsr: 7-bit LFSR with load, step, and pol output.

## Test plan
- Default params, one 48-beat frame (tdata = index, tuser on beat 47, tlast on beat 47), m_axis_tready = 1 → expected output:
  - 64 beats; slots 0 and 27..37 are 0
  - pilots 7/43/57 = 0x0000_7FFF, pilot 21 = 0x0000_8001
  - tuser and tlast on beat 63
- 10-symbol frame → pilot polarity per symbol follows 0,0,0,0,1,1,1,0,1,1: symbols 4..6 and 8..9 invert all four pilots.
- tlast on data beat 20 of symbol 2 → err_short pulse, remaining data slots 0, tlast at k = 63, then IDLE; the next frame's LFSR restarts at seed.
- Random m_axis_tready (50%) and random s_axis_tvalid → output sequence identical to the no-stall run; no data held changes while stalled.
- tuser on data beat 30 → err_align pulse; mapping continues unaffected.
- Reset pulsed at slot 40 of symbol 1 → all outputs 0 at once; a fresh frame maps correctly with pol = 0 for its first symbol.
